// File: rtl/cond_branch_unit.sv
// Registered ALU-flag holder and branch-condition evaluator with valid/ready request port.
// Optional unsigned compares (br_unsigned port) enabled by defining COND_UNSIGNED_EN.
module cond_branch_unit #(
    parameter int WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic             alu_overflow,
    input  logic             br_valid,
    input  logic [2:0]       br_opcode,
`ifdef COND_UNSIGNED_EN
    input  logic             br_unsigned,
`endif
    output logic             br_ready,
    input  logic             flush,
    output logic             taken_valid,
    output logic             taken,
    output logic [3:0]       flags_out,
    output logic             flags_valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q, flags_d;
    logic       fv_q;
    logic [2:0] op_q, op_d;
    logic       taken_q, taken_d;
`ifdef COND_UNSIGNED_EN
    logic       uns_q, uns_d;
    logic       uns_sel;
`endif

    logic       accept;
    logic [2:0] op_sel;
    logic       z_new, lt_new, le_new;
    logic       taken_eval;

    function automatic logic eval(input logic [2:0] op,
                                  input logic z,
                                  input logic lt,
                                  input logic le);
        logic r;
        r = 1'b0;
        unique case (op)
            3'b000: r = 1'b0;
            3'b001: r = z;
            3'b010: r = lt;
            3'b011: r = le;
            3'b100: r = 1'b1;
            3'b101: r = ~z;
            3'b110: r = ~le;
            3'b111: r = ~lt;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    // Flags visible to an evaluation on this edge: bypass the incoming ALU update.
    always_comb begin
        flags_d = flags_q;
        if (alu_valid) begin
            flags_d = {(alu_result == '0), alu_result[WIDTH-1],
                       alu_carry, alu_overflow};
        end
    end

    assign accept = br_valid & br_ready & ~flush;
    assign op_sel = (state_q == WAIT) ? op_q : br_opcode;
    assign z_new  = flags_d[3];

`ifdef COND_UNSIGNED_EN
    assign uns_sel = (state_q == WAIT) ? uns_q : br_unsigned;
    assign lt_new  = uns_sel ? flags_d[1] : (flags_d[2] ^ flags_d[0]);
`else
    assign lt_new  = flags_d[2] ^ flags_d[0];
`endif
    assign le_new     = lt_new | z_new;
    assign taken_eval = eval(op_sel, z_new, lt_new, le_new);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        taken_d = taken_q;
`ifdef COND_UNSIGNED_EN
        uns_d   = uns_q;
`endif
        if (flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE, RESP: begin
                    state_d = IDLE;
                    if (accept) begin
                        op_d = br_opcode;
`ifdef COND_UNSIGNED_EN
                        uns_d = br_unsigned;
`endif
                        if (fv_q || alu_valid || br_opcode[1:0] == 2'b00) begin
                            state_d = RESP;
                            taken_d = taken_eval;
                        end else begin
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (alu_valid) begin
                        state_d = RESP;
                        taken_d = taken_eval;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        br_ready    = (state_q != WAIT);
        taken_valid = (state_q == RESP);
        taken       = taken_q;
        flags_out   = flags_q;
        flags_valid = fv_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
            fv_q    <= 1'b0;
            op_q    <= '0;
            taken_q <= 1'b0;
`ifdef COND_UNSIGNED_EN
            uns_q   <= 1'b0;
`endif
        end else begin
            flags_q <= flags_d;
            fv_q    <= fv_q | alu_valid;
            op_q    <= op_d;
            taken_q <= taken_d;
`ifdef COND_UNSIGNED_EN
            uns_q   <= uns_d;
`endif
        end
    end

endmodule

// File: tb/tb_cond_branch_unit.sv
// Directed bench for cond_branch_unit: handshake, WAIT/bypass paths, flush and async reset.
module tb_cond_branch_unit;

    logic       clock = 1'b0;
    logic       reset;
    logic       alu_valid;
    logic [7:0] alu_result;
    logic       alu_carry;
    logic       alu_overflow;
    logic       br_valid;
    logic [2:0] br_opcode;
    logic       br_unsigned;
    logic       br_ready;
    logic       flush;
    logic       taken_valid;
    logic       taken;
    logic [3:0] flags_out;
    logic       flags_valid;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    cond_branch_unit #(.WIDTH(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .alu_valid    (alu_valid),
        .alu_result   (alu_result),
        .alu_carry    (alu_carry),
        .alu_overflow (alu_overflow),
        .br_valid     (br_valid),
        .br_opcode    (br_opcode),
`ifdef COND_UNSIGNED_EN
        .br_unsigned  (br_unsigned),
`endif
        .br_ready     (br_ready),
        .flush        (flush),
        .taken_valid  (taken_valid),
        .taken        (taken),
        .flags_out    (flags_out),
        .flags_valid  (flags_valid)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in();
        alu_valid    = 1'b0;
        alu_result   = 8'h00;
        alu_carry    = 1'b0;
        alu_overflow = 1'b0;
        br_valid     = 1'b0;
        br_opcode    = 3'b000;
        br_unsigned  = 1'b0;
        flush        = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_rdy"}, 8'(br_ready), 8'h1);
        chk({tag, "_tv"}, 8'(taken_valid), 8'h0);
        chk({tag, "_tk"}, 8'(taken), 8'h0);
        chk({tag, "_fl"}, 8'(flags_out), 8'h0);
        chk({tag, "_fv"}, 8'(flags_valid), 8'h0);
    endtask

    initial begin
        idle_in();
        reset = 1'b1;
        #12;
        chk_reset_state("rst");
        step();
        reset = 1'b0;

        // op 001 with no flags yet -> WAIT
        br_valid = 1'b1; br_opcode = 3'b001;
        step();
        br_valid = 1'b0;
        chk("wait_rdy", 8'(br_ready), 8'h0);
        chk("wait_tv", 8'(taken_valid), 8'h0);
        step();
        chk("wait2_rdy", 8'(br_ready), 8'h0);
        alu_valid = 1'b1; alu_result = 8'h00;
        step();
        alu_valid = 1'b0;
        chk("wresp_tv", 8'(taken_valid), 8'h1);
        chk("wresp_tk", 8'(taken), 8'h1);
        chk("wresp_fl", 8'(flags_out), 8'h8);
        chk("wresp_fv", 8'(flags_valid), 8'h1);
        step();
        chk("after_tv", 8'(taken_valid), 8'h0);
        chk("after_tk_hold", 8'(taken), 8'h1);
        chk("after_rdy", 8'(br_ready), 8'h1);

        // N=1, V=0: LT=1, LE=1; back-to-back requests
        alu_valid = 1'b1; alu_result = 8'h80;
        step();
        alu_valid = 1'b0;
        chk("n_fl", 8'(flags_out), 8'h4);
        chk("n_idle_tv", 8'(taken_valid), 8'h0);
        br_valid = 1'b1; br_opcode = 3'b010;
        step();
        chk("lt_tv", 8'(taken_valid), 8'h1);
        chk("lt_tk", 8'(taken), 8'h1);
        chk("lt_rdy", 8'(br_ready), 8'h1);
        br_opcode = 3'b110;
        step();
        chk("nle_tv", 8'(taken_valid), 8'h1);
        chk("nle_tk", 8'(taken), 8'h0);
        br_opcode = 3'b111;
        step();
        chk("nlt_tv", 8'(taken_valid), 8'h1);
        chk("nlt_tk", 8'(taken), 8'h0);
        br_opcode = 3'b101;
        step();
        chk("nz_tk", 8'(taken), 8'h1);
        br_valid = 1'b0;
        step();
        chk("b2b_end_tv", 8'(taken_valid), 8'h0);

        // bypass: stored Z=1, new result 05 on the accepting edge
        alu_valid = 1'b1; alu_result = 8'h00;
        step();
        chk("z_fl", 8'(flags_out), 8'h8);
        alu_result = 8'h05;
        br_valid = 1'b1; br_opcode = 3'b001;
        step();
        alu_valid = 1'b0; br_valid = 1'b0;
        chk("byp_tv", 8'(taken_valid), 8'h1);
        chk("byp_tk", 8'(taken), 8'h0);
        chk("byp_fl", 8'(flags_out), 8'h0);
        br_valid = 1'b1; br_opcode = 3'b011;
        step();
        br_valid = 1'b0;
        chk("le0_tk", 8'(taken), 8'h0);
        step();

        // flush while in WAIT, flags still update
        reset = 1'b1;
        #2;
        reset = 1'b0;
        br_valid = 1'b1; br_opcode = 3'b010;
        step();
        br_valid = 1'b0;
        chk("fwait_rdy", 8'(br_ready), 8'h0);
        flush = 1'b1; alu_valid = 1'b1; alu_result = 8'h00;
        step();
        flush = 1'b0; alu_valid = 1'b0;
        chk("flush_rdy", 8'(br_ready), 8'h1);
        chk("flush_tv", 8'(taken_valid), 8'h0);
        chk("flush_fl", 8'(flags_out), 8'h8);
        step();
        chk("flush2_tv", 8'(taken_valid), 8'h0);

        // br_valid with flush is dropped
        flush = 1'b1; br_valid = 1'b1; br_opcode = 3'b100;
        step();
        flush = 1'b0; br_valid = 1'b0;
        chk("fdrop_tv", 8'(taken_valid), 8'h0);
        step();
        chk("fdrop2_tv", 8'(taken_valid), 8'h0);

        // async reset in the middle of a response
        br_valid = 1'b1; br_opcode = 3'b100;
        step();
        br_valid = 1'b0;
        chk("pre_rst_tv", 8'(taken_valid), 8'h1);
        chk("pre_rst_tk", 8'(taken), 8'h1);
        #2;
        reset = 1'b1;
        #1;
        chk_reset_state("mid");
        step();
        reset = 1'b0;

        // flag-independent opcodes without any flags
        br_valid = 1'b1; br_opcode = 3'b000;
        step();
        chk("never_tv", 8'(taken_valid), 8'h1);
        chk("never_tk", 8'(taken), 8'h0);
        br_opcode = 3'b100;
        step();
        br_valid = 1'b0;
        chk("always_tv", 8'(taken_valid), 8'h1);
        chk("always_tk", 8'(taken), 8'h1);
        step();
        chk("nf_tv", 8'(taken_valid), 8'h0);
        chk("nf_fv", 8'(flags_valid), 8'h0);
        chk("nf_rdy", 8'(br_ready), 8'h1);

`ifdef COND_UNSIGNED_EN
        alu_valid = 1'b1; alu_result = 8'hFE; alu_carry = 1'b1;
        step();
        alu_valid = 1'b0;
        br_valid = 1'b1; br_opcode = 3'b010; br_unsigned = 1'b1;
        step();
        chk("u_lt_tk", 8'(taken), 8'h1);
        br_unsigned = 1'b0;
        step();
        chk("s_lt_tk", 8'(taken), 8'h1);
        br_valid = 1'b0;
        alu_valid = 1'b1; alu_result = 8'h90; alu_carry = 1'b0;
        step();
        alu_valid = 1'b0;
        br_valid = 1'b1; br_unsigned = 1'b1;
        step();
        br_valid = 1'b0;
        chk("u_nb_tv", 8'(taken_valid), 8'h1);
        chk("u_nb_tk", 8'(taken), 8'h0);
        step();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
